// File: rtl/gcd_bus_pkg.sv
// Shared constants for the GCD bus master: register offsets, timing defaults
// and the state/phase encodings used by gcd_bus_master and gcd_bus_phy.
package gcd_bus_pkg;

    localparam logic [15:0] REG_START  = 16'h0010;
    localparam logic [15:0] REG_ARG1   = 16'h0020;
    localparam logic [15:0] REG_ARG2   = 16'h0030;
    localparam logic [15:0] REG_RESULT = 16'h0040;
    localparam logic [15:0] REG_STATUS = 16'h0050;

    localparam logic [15:0] DEF_BASE_ADDR    = 16'h0800;
    localparam int          DEF_STROBE_LEN   = 2;
    localparam int          DEF_POLL_GAP     = 4;
    localparam int          DEF_POLL_TIMEOUT = 1000;

    typedef enum logic [2:0] {
        S_IDLE, S_WR_A, S_WR_B, S_WR_GO, S_POLL, S_GAP, S_RD_RES, S_RESP
    } state_e;

    typedef enum logic [1:0] {
        P_IDLE, P_SETUP, P_STROBE, P_HOLD
    } phase_e;

endpackage

// File: rtl/gcd_bus_phy.sv
// Runs one peripheral bus access: SETUP (1), STROBE (STROBE_LEN), HOLD (1).
// done pulses during HOLD, when rdata carries the sampled read value.
module gcd_bus_phy
    import gcd_bus_pkg::*;
#(
    parameter int STROBE_LEN = DEF_STROBE_LEN
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        start_wr,
    input  logic [15:0] start_addr,
    input  logic [31:0] start_wdata,
    output logic        idle,
    output logic        done,
    output logic [31:0] rdata,
    output logic [15:0] saddress,
    output logic        srd,
    output logic        swr,
    output logic [31:0] sdata_out,
    input  logic [31:0] sdata_in
);

    localparam logic [3:0] STROBE_LAST = 4'(STROBE_LEN - 1);

    phase_e      phase_q, phase_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        wr_q, wr_d;
    logic [15:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        srd_q, srd_d;
    logic        swr_q, swr_d;

    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        srd_d   = 1'b0;
        swr_d   = 1'b0;
        case (phase_q)
            P_IDLE: begin
                if (start) begin
                    phase_d = P_SETUP;
                    wr_d    = start_wr;
                    addr_d  = start_addr;
                    wdata_d = start_wr ? start_wdata : 32'd0;
                end
            end
            P_SETUP: begin
                phase_d = P_STROBE;
                cnt_d   = 4'd0;
                srd_d   = ~wr_q;
                swr_d   = wr_q;
            end
            P_STROBE: begin
                if (cnt_q == STROBE_LAST) begin
                    phase_d = P_HOLD;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                    srd_d = srd_q;
                    swr_d = swr_q;
                end
            end
            P_HOLD: begin
                // Address/data return to zero so the bus reads as idle between accesses.
                phase_d = P_IDLE;
                wr_d    = 1'b0;
                addr_d  = 16'd0;
                wdata_d = 32'd0;
            end
            default: phase_d = P_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q <= P_IDLE;
            cnt_q   <= 4'd0;
            wr_q    <= 1'b0;
            addr_q  <= 16'd0;
            wdata_q <= 32'd0;
            srd_q   <= 1'b0;
            swr_q   <= 1'b0;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            srd_q   <= srd_d;
            swr_q   <= swr_d;
        end
    end

    assign idle      = (phase_q == P_IDLE);
    assign done      = (phase_q == P_HOLD);
    assign rdata     = (phase_q == P_HOLD && !wr_q) ? sdata_in : 32'd0;
    assign saddress  = addr_q;
    assign sdata_out = wdata_q;
    assign srd       = srd_q;
    assign swr       = swr_q;

endmodule

// File: rtl/gcd_bus_master.sv
// Drives a memory-mapped GCD peripheral: writes operands, starts it, polls status,
// reads the result. Define GCD_POLL_TIMEOUT_EN to bound polling with POLL_TIMEOUT.
module gcd_bus_master
    import gcd_bus_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR  = DEF_BASE_ADDR,
    parameter int          STROBE_LEN = DEF_STROBE_LEN,
    parameter int          POLL_GAP   = DEF_POLL_GAP
`ifdef GCD_POLL_TIMEOUT_EN
    , parameter int        POLL_TIMEOUT = DEF_POLL_TIMEOUT
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_a,
    input  logic [31:0] cmd_b,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic        res_err,
    output logic [15:0] saddress,
    output logic        srd,
    output logic        swr,
    output logic [31:0] sdata_out,
    input  logic [31:0] sdata_in,
    output logic [2:0]  state_dbg
);

    localparam logic [7:0] GAP_LAST = (POLL_GAP > 0) ? 8'(POLL_GAP - 1) : 8'd0;

    state_e      state_q, state_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic [31:0] res_data_q, res_data_d;
    logic [7:0]  gap_cnt_q, gap_cnt_d;

    logic        phy_start, phy_wr, phy_idle, phy_done;
    logic [15:0] phy_addr;
    logic [31:0] phy_wdata, phy_rdata;

`ifdef GCD_POLL_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(POLL_TIMEOUT - 1);
    logic [15:0] poll_cnt_q, poll_cnt_d;
    logic        res_err_q, res_err_d;
`endif

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        res_data_d = res_data_q;
        gap_cnt_d  = gap_cnt_q;
        phy_start  = 1'b0;
        phy_wr     = 1'b0;
        phy_addr   = 16'd0;
        phy_wdata  = 32'd0;
`ifdef GCD_POLL_TIMEOUT_EN
        poll_cnt_d = poll_cnt_q;
        res_err_d  = res_err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    a_d     = cmd_a;
                    b_d     = cmd_b;
                    state_d = S_WR_A;
                end
            end
            S_WR_A: begin
                phy_start = phy_idle;
                phy_wr    = 1'b1;
                phy_addr  = BASE_ADDR + REG_ARG1;
                phy_wdata = a_q;
                if (phy_done) state_d = S_WR_B;
            end
            S_WR_B: begin
                phy_start = phy_idle;
                phy_wr    = 1'b1;
                phy_addr  = BASE_ADDR + REG_ARG2;
                phy_wdata = b_q;
                if (phy_done) state_d = S_WR_GO;
            end
            S_WR_GO: begin
                phy_start = phy_idle;
                phy_wr    = 1'b1;
                phy_addr  = BASE_ADDR + REG_START;
                if (phy_done) begin
                    state_d = S_POLL;
`ifdef GCD_POLL_TIMEOUT_EN
                    poll_cnt_d = 16'd0;
`endif
                end
            end
            S_POLL: begin
                phy_start = phy_idle;
                phy_addr  = BASE_ADDR + REG_STATUS;
                if (phy_done) begin
                    if (phy_rdata[0]) begin
                        state_d = S_RD_RES;
                    end else begin
                        state_d   = (POLL_GAP == 0) ? S_POLL : S_GAP;
                        gap_cnt_d = 8'd0;
`ifdef GCD_POLL_TIMEOUT_EN
                        poll_cnt_d = poll_cnt_q + 16'd1;
                        if (poll_cnt_q == TIMEOUT_LAST) begin
                            state_d    = S_RESP;
                            res_data_d = 32'd0;
                            res_err_d  = 1'b1;
                        end
`endif
                    end
                end
            end
            S_GAP: begin
                // The next status read is launched in the last gap cycle so the bus
                // shows exactly POLL_GAP idle cycles between reads.
                phy_addr = BASE_ADDR + REG_STATUS;
                if (gap_cnt_q == GAP_LAST) begin
                    phy_start = 1'b1;
                    state_d   = S_POLL;
                end else begin
                    gap_cnt_d = gap_cnt_q + 8'd1;
                end
            end
            S_RD_RES: begin
                phy_start = phy_idle;
                phy_addr  = BASE_ADDR + REG_RESULT;
                if (phy_done) begin
                    res_data_d = phy_rdata;
                    state_d    = S_RESP;
`ifdef GCD_POLL_TIMEOUT_EN
                    res_err_d = 1'b0;
`endif
                end
            end
            S_RESP: begin
                if (res_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            a_q        <= 32'd0;
            b_q        <= 32'd0;
            res_data_q <= 32'd0;
            gap_cnt_q  <= 8'd0;
`ifdef GCD_POLL_TIMEOUT_EN
            poll_cnt_q <= 16'd0;
            res_err_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            res_data_q <= res_data_d;
            gap_cnt_q  <= gap_cnt_d;
`ifdef GCD_POLL_TIMEOUT_EN
            poll_cnt_q <= poll_cnt_d;
            res_err_q  <= res_err_d;
`endif
        end
    end

    gcd_bus_phy #(
        .STROBE_LEN(STROBE_LEN)
    ) u_phy (
        .clk        (clk),
        .reset      (reset),
        .start      (phy_start),
        .start_wr   (phy_wr),
        .start_addr (phy_addr),
        .start_wdata(phy_wdata),
        .idle       (phy_idle),
        .done       (phy_done),
        .rdata      (phy_rdata),
        .saddress   (saddress),
        .srd        (srd),
        .swr        (swr),
        .sdata_out  (sdata_out),
        .sdata_in   (sdata_in)
    );

    // Ready is masked by reset itself so it reads 0 while reset is held.
    assign cmd_ready = (state_q == S_IDLE) && !reset;
    assign res_valid = (state_q == S_RESP);
    assign res_data  = res_data_q;
    assign state_dbg = state_q;
`ifdef GCD_POLL_TIMEOUT_EN
    assign res_err = res_err_q;
`else
    assign res_err = 1'b0;
`endif

endmodule

// File: tb/tb_gcd_bus_master.sv
// Bench for gcd_bus_master with a behavioural GCD peripheral on the strobe bus.
// Timeout scenario is built only when GCD_POLL_TIMEOUT_EN is defined.
module tb_gcd_bus_master;
    import gcd_bus_pkg::*;

    localparam int STROBE_LEN = 2;
    localparam int POLL_GAP   = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_a = 32'd0;
    logic [31:0] cmd_b = 32'd0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [31:0] res_data;
    logic        res_err;
    logic [15:0] saddress;
    logic        srd, swr;
    logic [31:0] sdata_out;
    logic [31:0] sdata_in = 32'd0;
    logic [2:0]  state_dbg;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    gcd_bus_master #(
        .BASE_ADDR (16'h0800),
        .STROBE_LEN(STROBE_LEN),
        .POLL_GAP  (POLL_GAP)
`ifdef GCD_POLL_TIMEOUT_EN
        , .POLL_TIMEOUT(3)
`endif
    ) dut (
        .clk      (clk),
        .reset    (rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_a    (cmd_a),
        .cmd_b    (cmd_b),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_data (res_data),
        .res_err  (res_err),
        .saddress (saddress),
        .srd      (srd),
        .swr      (swr),
        .sdata_out(sdata_out),
        .sdata_in (sdata_in),
        .state_dbg(state_dbg)
    );

    // ---------------- peripheral model ----------------
    logic [31:0] p_a = 32'd0, p_b = 32'd0, p_res = 32'd0;
    logic        p_started = 1'b0;
    int          done_delay = 0;
    int          polls_left = 0;
    int          status_reads = 0;
    logic [47:0] wr_log[$];
    logic [47:0] exp_q[$];

    function automatic logic [31:0] gcd_ref(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] t;
        while (y != 32'd0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    always @(posedge swr) begin
        wr_log.push_back({saddress, sdata_out});
        case (saddress)
            16'h0820: p_a = sdata_out;
            16'h0830: p_b = sdata_out;
            16'h0810: begin
                p_res      = gcd_ref(p_a, p_b);
                polls_left = done_delay;
                p_started  = 1'b1;
            end
            default: ;
        endcase
    end

    always @(posedge srd) begin
        case (saddress)
            16'h0850: begin
                status_reads++;
                if (p_started && polls_left == 0) sdata_in = 32'h8000_0001;
                else begin
                    sdata_in = 32'hFFFF_FFFE;
                    if (polls_left > 0) polls_left--;
                end
            end
            16'h0840: sdata_in = p_res;
            default:  sdata_in = 32'hDEAD_BEEF;
        endcase
    end

    // ---------------- bus monitor ----------------
    int   overlap_cnt = 0;
    int   strobe_bad = 0;
    int   strobe_run = 0;
    int   mon_idle = 0;
    logic mon_seen = 1'b0;
    int   gap_log[$];

    always @(negedge clk) begin
        if (srd && swr) overlap_cnt++;
        if (srd || swr) strobe_run++;
        else begin
            if (strobe_run != 0 && strobe_run != STROBE_LEN) strobe_bad++;
            strobe_run = 0;
        end
        if (saddress == 16'h0850) begin
            if (mon_seen && mon_idle > 0) gap_log.push_back(mon_idle);
            mon_seen = 1'b1;
            mon_idle = 0;
        end else if (saddress == 16'h0000) begin
            if (mon_seen) mon_idle++;
        end else begin
            mon_seen = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_cmd(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_a     = a;
        cmd_b     = b;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_res(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (res_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic accept_res;
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({cmd_ready, res_valid, res_err, srd, swr} !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got %b want 00000", {cmd_ready, res_valid, res_err, srd, swr});
        end
        tests_run++;
        if ({saddress, sdata_out, res_data} !== 80'd0) begin
            tests_failed++;
            $display("FAIL reset_bus: got addr %h wdata %h res %h want 0", saddress, sdata_out, res_data);
        end
        tests_run++;
        if (state_dbg !== S_IDLE) begin
            tests_failed++;
            $display("FAIL reset_state: got %0d want %0d", state_dbg, S_IDLE);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        tests_run++;
        if (cmd_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_release_ready: got %b want 1", cmd_ready);
        end
    endtask

    task automatic test_basic;
        logic ok;
        int   wb;
        done_delay = 0;
        wb = wr_log.size();
        exp_q.delete();
        exp_q.push_back({16'h0820, 32'd48});
        exp_q.push_back({16'h0830, 32'd18});
        exp_q.push_back({16'h0810, 32'd0});
        send_cmd(32'd48, 32'd18);
        wait_res(ok);
        tests_run++;
        if (ok !== 1'b1) begin
            tests_failed++;
            $display("FAIL basic_timeout: res_valid got %b want 1", res_valid);
        end
        tests_run++;
        if (res_data !== 32'd6 || res_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_result: got data %0d err %b want 6 0", res_data, res_err);
        end
        accept_res;
        tests_run++;
        if (res_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL basic_release: got valid %b ready %b want 0 1", res_valid, cmd_ready);
        end
        tests_run++;
        if (wr_log.size() - wb !== 3) begin
            tests_failed++;
            $display("FAIL basic_write_count: got %0d want 3", wr_log.size() - wb);
        end
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (wr_log[wb + i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL basic_write_%0d: got %h want %h", i, wr_log[wb + i], exp_q[i]);
            end
        end
        exp_q.delete();
    endtask

    task automatic test_vectors;
        logic [31:0] va[4] = '{32'd17, 32'hFFFF_FFFF, 32'd1071, 32'd0};
        logic [31:0] vb[4] = '{32'd0,  32'hFFFF_FFFF, 32'd462,  32'd5};
        logic [31:0] vr[4] = '{32'd17, 32'hFFFF_FFFF, 32'd21,   32'd5};
        logic ok;
        done_delay = 0;
        for (int i = 0; i < 4; i++) begin
            send_cmd(va[i], vb[i]);
            wait_res(ok);
            tests_run++;
            if (ok !== 1'b1) begin
                tests_failed++;
                $display("FAIL vec%0d_timeout: res_valid got %b want 1", i, res_valid);
            end
            tests_run++;
            if (res_data !== vr[i] || res_err !== 1'b0) begin
                tests_failed++;
                $display("FAIL vec%0d_result: got %h err %b want %h 0", i, res_data, res_err, vr[i]);
            end
            accept_res;
        end
    endtask

    task automatic test_poll_gap;
        logic ok;
        int   rb, gb, ob, sb, bad;
        done_delay = 10;
        rb = status_reads;
        gb = gap_log.size();
        ob = overlap_cnt;
        sb = strobe_bad;
        send_cmd(32'd100, 32'd75);
        wait_res(ok);
        tests_run++;
        if (ok !== 1'b1 || res_data !== 32'd25) begin
            tests_failed++;
            $display("FAIL poll_result: got ok %b data %0d want 1 25", ok, res_data);
        end
        accept_res;
        tests_run++;
        if (status_reads - rb !== 11) begin
            tests_failed++;
            $display("FAIL poll_reads: got %0d want 11", status_reads - rb);
        end
        tests_run++;
        if (gap_log.size() - gb !== 10) begin
            tests_failed++;
            $display("FAIL poll_gap_count: got %0d want 10", gap_log.size() - gb);
        end
        bad = 0;
        for (int i = gb; i < gap_log.size(); i++) if (gap_log[i] != POLL_GAP) bad++;
        tests_run++;
        if (bad !== 0) begin
            tests_failed++;
            $display("FAIL poll_gap_len: got %0d gaps not %0d cycles want 0", bad, POLL_GAP);
        end
        tests_run++;
        if (overlap_cnt - ob !== 0 || strobe_bad - sb !== 0) begin
            tests_failed++;
            $display("FAIL poll_strobes: got overlap %0d bad_len %0d want 0 0", overlap_cnt - ob, strobe_bad - sb);
        end
        done_delay = 0;
    endtask

    task automatic test_back_to_back;
        logic ok;
        int   wb, bad;
        done_delay = 0;
        send_cmd(32'd48, 32'd18);
        wait_res(ok);
        tests_run++;
        if (ok !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_first_timeout: res_valid got %b want 1", res_valid);
        end
        wb = wr_log.size();
        cmd_valid = 1'b1;
        cmd_a     = 32'd21;
        cmd_b     = 32'd14;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (res_data !== 32'd6 || res_valid !== 1'b1 || cmd_ready !== 1'b0) bad++;
        end
        tests_run++;
        if (bad !== 0) begin
            tests_failed++;
            $display("FAIL bp_hold: got %0d unstable cycles want 0", bad);
        end
        tests_run++;
        if (wr_log.size() !== wb) begin
            tests_failed++;
            $display("FAIL bp_no_queue: got %0d writes want 0", wr_log.size() - wb);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        tests_run++;
        if (res_valid !== 1'b0 || cmd_ready !== 1'b1 || state_dbg !== S_IDLE) begin
            tests_failed++;
            $display("FAIL bp_idle: got valid %b ready %b state %0d want 0 1 0", res_valid, cmd_ready, state_dbg);
        end
        @(negedge clk);
        tests_run++;
        if (cmd_ready !== 1'b0 || state_dbg !== S_WR_A) begin
            tests_failed++;
            $display("FAIL bp_accept: got ready %b state %0d want 0 %0d", cmd_ready, state_dbg, S_WR_A);
        end
        cmd_valid = 1'b0;
        wait_res(ok);
        tests_run++;
        if (ok !== 1'b1 || res_data !== 32'd7) begin
            tests_failed++;
            $display("FAIL bp_second_result: got ok %b data %0d want 1 7", ok, res_data);
        end
        tests_run++;
        if (wr_log[wb] !== {16'h0820, 32'd21}) begin
            tests_failed++;
            $display("FAIL bp_second_operand: got %h want 000820_00000015", wr_log[wb]);
        end
        accept_res;
    endtask

    task automatic test_reset_mid;
        logic ok, found;
        int   wb, hits;
        done_delay = 0;
        wb = wr_log.size();
        send_cmd(32'd48, 32'd18);
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (swr === 1'b1 && saddress === 16'h0830) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        tests_run++;
        if (found !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_mid_find: strobe on 0x830 got %b want 1", found);
        end
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if (swr !== 1'b0 || saddress !== 16'h0000 || state_dbg !== S_IDLE || cmd_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_mid_async: got swr %b addr %h state %0d ready %b want 0 0000 0 0", swr, saddress, state_dbg, cmd_ready);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        hits = 0;
        for (int i = wb; i < wr_log.size(); i++) if (wr_log[i][47:32] == 16'h0810) hits++;
        tests_run++;
        if (hits !== 0 || res_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_mid_abort: got start_writes %0d valid %b ready %b want 0 0 1", hits, res_valid, cmd_ready);
        end
        send_cmd(32'd48, 32'd18);
        wait_res(ok);
        tests_run++;
        if (ok !== 1'b1 || res_data !== 32'd6 || res_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_mid_recover: got ok %b data %0d err %b want 1 6 0", ok, res_data, res_err);
        end
        accept_res;
    endtask

`ifdef GCD_POLL_TIMEOUT_EN
    task automatic test_timeout;
        logic ok;
        int   rb;
        done_delay = 1000000;
        rb = status_reads;
        send_cmd(32'd48, 32'd18);
        wait_res(ok);
        tests_run++;
        if (ok !== 1'b1) begin
            tests_failed++;
            $display("FAIL timeout_wait: res_valid got %b want 1", res_valid);
        end
        tests_run++;
        if (status_reads - rb !== 3) begin
            tests_failed++;
            $display("FAIL timeout_reads: got %0d want 3", status_reads - rb);
        end
        tests_run++;
        if (res_err !== 1'b1 || res_data !== 32'd0) begin
            tests_failed++;
            $display("FAIL timeout_result: got err %b data %h want 1 0", res_err, res_data);
        end
        accept_res;
        done_delay = 0;
    endtask
`endif

    initial begin
        test_reset;
        test_basic;
        test_vectors;
        test_poll_gap;
        test_back_to_back;
        test_reset_mid;
`ifdef GCD_POLL_TIMEOUT_EN
        test_timeout;
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/gcd_bus_master.md
GCD_BUS_MASTER -- requirements
Module: gcd_bus_master

Interface
REQ-001 Parameter BASE_ADDR, 16'h0800, base added to register offsets 0x10 (start), 0x20 (arg1), 0x30 (arg2), 0x40 (result), 0x50 (status).
REQ-002 Parameter STROBE_LEN, 2, clock cycles each srd/swr strobe stays high (legal 1..15).
REQ-003 Parameter POLL_GAP, 4, idle cycles between consecutive status reads (legal 0..255).
REQ-004 Port clk, input, 1, single clock; all logic on rising edge.
REQ-005 Port reset, input, 1, asynchronous active-high reset.
REQ-006 Port cmd_valid, input, 1, local request: compute GCD of cmd_a, cmd_b.
REQ-007 Port cmd_ready, output, 1, high only in IDLE; transfer when cmd_valid and cmd_ready are both high on a rising edge.
REQ-008 Ports cmd_a and cmd_b, input, 32 each, operands; captured on transfer.
REQ-009 Port res_valid, output, 1, result available; holds until accepted.
REQ-010 Port res_ready, input, 1, consumer accepts result when res_valid and res_ready are both high.
REQ-011 Port res_data, output, 32, GCD value read from the peripheral.
REQ-012 Port res_err, output, 1, qualified by res_valid; 1 means poll timeout.
REQ-013 Port saddress, output, 16, bus address to the peripheral.
REQ-014 Ports srd and swr, output, 1 each, read and write strobes; the peripheral acts on their rising edge.
REQ-015 Port sdata_out, output, 32, write data (drives the peripheral's sdata_in).
REQ-016 Port sdata_in, input, 32, read data (from the peripheral's sdata_out).

Function
REQ-017 States: IDLE, WR_A, WR_B, WR_GO, POLL, GAP, RD_RES, RESP; each bus state runs the phases SETUP (1 cycle), STROBE (STROBE_LEN cycles), HOLD (1 cycle).
REQ-018 Address and data are stable from SETUP through HOLD; srd and swr are never high together, and are high only in STROBE.
REQ-019 Sequence: WR_A writes the operand a to BASE+0x20; WR_B writes b to BASE+0x30; WR_GO writes 0 to BASE+0x10.
REQ-020 POLL reads BASE+0x50 and samples sdata_in in HOLD; if bit0 is 1, go to RD_RES; otherwise go to GAP.
REQ-021 GAP idles POLL_GAP cycles with strobes low, then returns to POLL (POLL directly when POLL_GAP is 0).
REQ-022 RD_RES reads BASE+0x40, captures sdata_in into res_data in HOLD, and enters RESP with res_valid=1 and res_err=0.
REQ-023 RESP holds res_valid, res_data and res_err stable until res_ready; then IDLE on the next cycle.
REQ-024 cmd_valid outside IDLE is ignored and never queued; sdata_in bits 31:1 are ignored during POLL.
REQ-025 When the bus is idle, saddress=0, sdata_out=0, srd=0 and swr=0.
REQ-026 Operand b=0 needs no special handling; the peripheral returns a.

Reset
REQ-027 Reset asserted at any time: state IDLE, all outputs 0 except cmd_ready=0 while reset is high, strobes low immediately, and no partial transfer completes.
REQ-028 cmd_ready=1 on the first rising edge after reset is released.

Configuration
REQ-029 With macro GCD_POLL_TIMEOUT_EN defined: a 16-bit poll counter aborts after parameter POLL_TIMEOUT (default 1000) status reads without done, and enters RESP with res_err=1 and res_data=0.
REQ-030 Without GCD_POLL_TIMEOUT_EN: polling is unbounded, res_err is tied to 0, and no counter logic exists.

Structure
REQ-031 Package gcd_bus_pkg holds the register offset constants, the state enum typedef, and the default timing constants.
REQ-032 One sub-module, gcd_bus_phy, sequences a single bus access (SETUP/STROBE/HOLD, read capture, done pulse); gcd_bus_master's FSM issues accesses to it.

Verification
REQ-033 cmd a=48, b=18 against a gpioemu model -> writes 0x820=48, 0x830=18, then 0x810; res_valid with res_data=6, res_err=0.
REQ-034 a=17, b=0 -> res_data=17; a=0xFFFFFFFF, b=0xFFFFFFFF -> res_data=0xFFFFFFFF.
REQ-035 Peripheral done delayed 10 polls, POLL_GAP=4 -> exactly 11 status reads, with 4 idle cycles between each pair and no strobe overlap.
REQ-036 res_ready held low 20 cycles with cmd_valid held high -> res_data stable, cmd_ready=0 throughout, and the second command is accepted only after IDLE.
REQ-037 Reset pulsed during STROBE of WR_B -> swr=0 asynchronously, state IDLE, no write to 0x810, and the next command completes normally.
REQ-038 With GCD_POLL_TIMEOUT_EN, POLL_TIMEOUT=3, done never set -> 3 reads, then res_valid=1, res_err=1, res_data=0.
